// File: rtl/gtp_pll_init.sv
// Power-up and reset sequencer for GTPE2 PLL0 and its TX path. It retries on lock or reset-done timeout,
// and it reports READY or a sticky FAIL. Every output is registered and decoded from the next state.
module gtp_pll_init #(
    parameter int PD_CYCLES    = 16,
    parameter int RESET_CYCLES = 32,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int DONE_TIMEOUT = 65536,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       tx_resetdone,
    output logic       pll_pd,
    output logic       pll_reset,
    output logic       gttx_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count
);

    localparam int MAX_A = (PD_CYCLES > RESET_CYCLES) ? PD_CYCLES : RESET_CYCLES;
    localparam int MAX_B = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] PD_LAST   = CW'(PD_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);
    localparam logic [3:0]    MAX_R     = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_POWERDOWN,
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_TX_RESET,
        ST_WAIT_DONE,
        ST_READY,
        ST_RETRY,
        ST_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          lock_meta_q, lock_sync_q;
    logic          done_meta_q, done_sync_q;
    logic          pll_pd_q, pll_reset_q, gttx_reset_q, ready_q, fail_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        unique case (state_q)
            ST_POWERDOWN: if (cnt_q == PD_LAST) state_d = ST_PLL_RESET;
            ST_PLL_RESET: if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_sync_q)             state_d = ST_TX_RESET;
                else if (cnt_q == LOCK_LAST) state_d = ST_RETRY;
            end
            ST_TX_RESET: begin
                if (!lock_sync_q)           state_d = ST_RETRY;
                else if (cnt_q == RST_LAST) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!lock_sync_q) begin
                    state_d = ST_RETRY;
                end else if (done_sync_q) begin
                    state_d = ST_READY;
                    retry_d = 4'd0;
                end else if (cnt_q == DONE_LAST) begin
                    state_d = ST_RETRY;
                end
            end
            // Lock loss after bring-up is a normal re-lock, not a failed attempt.
            ST_READY: if (!lock_sync_q) state_d = ST_PLL_RESET;
            ST_RETRY: begin
                if (retry_q < MAX_R) begin
                    state_d = ST_PLL_RESET;
                    retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_POWERDOWN;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_POWERDOWN;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            done_meta_q  <= 1'b0;
            done_sync_q  <= 1'b0;
            pll_pd_q     <= 1'b1;
            pll_reset_q  <= 1'b1;
            gttx_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_sync_q <= lock_meta_q;
            done_meta_q <= tx_resetdone;
            done_sync_q <= done_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            // Decode from the next state so outputs change in the first cycle of that state.
            pll_pd_q     <= (state_d == ST_POWERDOWN) || (state_d == ST_FAIL);
            pll_reset_q  <= (state_d == ST_POWERDOWN) || (state_d == ST_PLL_RESET) ||
                            (state_d == ST_RETRY)     || (state_d == ST_FAIL);
            gttx_reset_q <= (state_d != ST_WAIT_DONE) && (state_d != ST_READY);
            ready_q      <= (state_d == ST_READY);
            fail_q       <= (state_d == ST_FAIL);
        end
    end

    assign pll_pd      = pll_pd_q;
    assign pll_reset   = pll_reset_q;
    assign gttx_reset  = gttx_reset_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_gtp_pll_init.sv
// Testbench for gtp_pll_init. Expected output snapshots, keyed by cycle, are queued with each scenario.
// They are popped and compared when the run reaches that cycle.
module tb_gtp_pll_init;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       tx_resetdone = 1'b0;
    logic       pll_pd, pll_reset, gttx_reset, ready, fail;
    logic [3:0] retry_count;
    logic [8:0] obs;

    typedef struct {
        int         cyc;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    gtp_pll_init #(
        .PD_CYCLES   (4),
        .RESET_CYCLES(8),
        .LOCK_TIMEOUT(32),
        .DONE_TIMEOUT(16),
        .MAX_RETRIES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .tx_resetdone(tx_resetdone),
        .pll_pd      (pll_pd),
        .pll_reset   (pll_reset),
        .gttx_reset  (gttx_reset),
        .ready       (ready),
        .fail        (fail),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    assign obs = {pll_pd, pll_reset, gttx_reset, ready, fail, retry_count};

    function automatic logic [8:0] ev(input bit pd, input bit pr, input bit gt,
                                      input bit rd, input bit fl, input int rc);
        logic [3:0] r;
        r = rc[3:0];
        return {pd, pr, gt, rd, fl, r};
    endfunction

    task automatic push(input int c, input logic [8:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Cycle 0 is the first cycle after the last edge that samples rst high.
    task automatic apply_reset(input logic lock, input logic done);
        pll_lock     = lock;
        tx_resetdone = done;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        apply_reset(1'b0, 1'b0);
        push(0, ev(1, 1, 1, 0, 0, 0));
        push(3, ev(1, 1, 1, 0, 0, 0));
        while (sb.size() > 0) begin
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL reset cyc=%0d got=%b want=%b", cyc, obs, e.v);
                end
            end
            if (sb.size() > 0) step();
        end
    endtask

    task automatic test_nominal();
        exp_t e;
        apply_reset(1'b0, 1'b0);
        push(0,  ev(1, 1, 1, 0, 0, 0));
        push(4,  ev(0, 1, 1, 0, 0, 0));
        push(11, ev(0, 1, 1, 0, 0, 0));
        push(12, ev(0, 0, 1, 0, 0, 0));
        push(30, ev(0, 0, 1, 0, 0, 0));
        push(31, ev(0, 0, 0, 0, 0, 0));
        push(42, ev(0, 0, 0, 0, 0, 0));
        push(43, ev(0, 0, 0, 1, 0, 0));
        push(50, ev(0, 0, 0, 1, 0, 0));
        while (sb.size() > 0) begin
            if (cyc == 20) pll_lock = 1'b1;
            if (cyc == 40) tx_resetdone = 1'b1;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL nominal cyc=%0d got=%b want=%b", cyc, obs, e.v);
                end
            end
            if (sb.size() > 0) step();
        end
    endtask

    task automatic test_lock_never();
        exp_t e;
        apply_reset(1'b0, 1'b0);
        push(43,  ev(0, 0, 1, 0, 0, 0));
        push(44,  ev(0, 1, 1, 0, 0, 0));
        push(45,  ev(0, 1, 1, 0, 0, 1));
        push(84,  ev(0, 0, 1, 0, 0, 1));
        push(85,  ev(0, 1, 1, 0, 0, 1));
        push(86,  ev(0, 1, 1, 0, 0, 2));
        push(126, ev(0, 1, 1, 0, 0, 2));
        push(127, ev(1, 1, 1, 0, 1, 2));
        push(180, ev(1, 1, 1, 0, 1, 2));
        while (sb.size() > 0) begin
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL lock_never cyc=%0d got=%b want=%b", cyc, obs, e.v);
                end
            end
            if (sb.size() > 0) step();
        end
    endtask

    task automatic test_lock_loss();
        exp_t e;
        apply_reset(1'b1, 1'b1);
        push(0,  ev(1, 1, 1, 0, 0, 0));
        push(22, ev(0, 0, 0, 1, 0, 0));
        push(32, ev(0, 0, 0, 1, 0, 0));
        push(33, ev(0, 1, 1, 0, 0, 0));
        push(40, ev(0, 1, 1, 0, 0, 0));
        push(41, ev(0, 0, 1, 0, 0, 0));
        push(50, ev(0, 0, 0, 0, 0, 0));
        push(51, ev(0, 0, 0, 1, 0, 0));
        push(62, ev(0, 0, 0, 1, 0, 0));
        while (sb.size() > 0) begin
            if (cyc == 30) pll_lock = 1'b0;
            if (cyc == 35) pll_lock = 1'b1;
            if (cyc == 55) tx_resetdone = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL lock_loss cyc=%0d got=%b want=%b", cyc, obs, e.v);
                end
            end
            if (sb.size() > 0) step();
        end
    endtask

    task automatic test_done_timeout();
        exp_t e;
        apply_reset(1'b1, 1'b0);
        push(36, ev(0, 0, 0, 0, 0, 0));
        push(37, ev(0, 1, 1, 0, 0, 0));
        push(38, ev(0, 1, 1, 0, 0, 1));
        push(55, ev(0, 0, 0, 0, 0, 1));
        push(56, ev(0, 0, 0, 1, 0, 0));
        while (sb.size() > 0) begin
            if (cyc == 40) tx_resetdone = 1'b1;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL done_timeout cyc=%0d got=%b want=%b", cyc, obs, e.v);
                end
            end
            if (sb.size() > 0) step();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        apply_reset(1'b0, 1'b0);
        push(6,  ev(0, 1, 1, 0, 0, 0));
        push(7,  ev(1, 1, 1, 0, 0, 0));
        push(10, ev(1, 1, 1, 0, 0, 0));
        push(11, ev(0, 1, 1, 0, 0, 0));
        push(18, ev(0, 1, 1, 0, 0, 0));
        push(19, ev(0, 0, 1, 0, 0, 0));
        while (sb.size() > 0) begin
            if (cyc == 6) rst = 1'b1;
            if (cyc == 7) rst = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL reset_mid cyc=%0d got=%b want=%b", cyc, obs, e.v);
                end
            end
            if (sb.size() > 0) step();
        end
    endtask

    // Synced lock first seen on the last WAIT_LOCK cycle, then lost during TX_RESET.
    task automatic test_simultaneous();
        exp_t e;
        apply_reset(1'b0, 1'b0);
        push(43, ev(0, 0, 1, 0, 0, 0));
        push(44, ev(0, 0, 1, 0, 0, 0));
        push(48, ev(0, 0, 1, 0, 0, 0));
        push(49, ev(0, 1, 1, 0, 0, 0));
        push(50, ev(0, 1, 1, 0, 0, 1));
        while (sb.size() > 0) begin
            if (cyc == 41) pll_lock = 1'b1;
            if (cyc == 46) pll_lock = 1'b0;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.v) begin
                    errors++;
                    $display("FAIL simultaneous cyc=%0d got=%b want=%b", cyc, obs, e.v);
                end
            end
            if (sb.size() > 0) step();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_never();
        test_lock_loss();
        test_done_timeout();
        test_reset_mid();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net in case any scenario stalls.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        errors++;
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
